// File: rtl/level_detector_if.sv
// Sample/result bundle for level_detector: sample strobe in, window statistics
// out with a valid/ready handshake. The DUT uses the slave modport.
interface level_detector_if #(
  parameter int NB_DATA = 8
);
  logic                      i_en;
  logic signed [NB_DATA-1:0] i_data;
  logic signed [NB_DATA-1:0] o_max;
  logic signed [NB_DATA-1:0] o_min;
  logic [NB_DATA:0]          o_pkpk;
  logic [NB_DATA-1:0]        o_mean_abs;
  logic                      o_valid;
  logic                      i_ready;
  logic                      o_overrun;

  modport slave (
    input  i_en, i_data, i_ready,
    output o_max, o_min, o_pkpk, o_mean_abs, o_valid, o_overrun
  );

  modport master (
    output i_en, i_data, i_ready,
    input  o_max, o_min, o_pkpk, o_mean_abs, o_valid, o_overrun
  );
endinterface

// File: rtl/level_detector.sv
// Windowed max/min/peak-to-peak (and optional mean |x|) of a signed sample stream.
// Define LEVEL_DETECTOR_MEAN_ABS_EN to build the mean-absolute-value accumulator.
module level_detector #(
  parameter int NB_DATA  = 8,
  parameter int LOG2_WIN = 6
) (
  input logic            i_clock,
  input logic            i_reset,
  level_detector_if.slave bus
);

  localparam int NB_SUM = NB_DATA + LOG2_WIN;

  typedef enum logic {EMPTY, PENDING} state_t;

  state_t                    state, next_state;
  logic [LOG2_WIN-1:0]       count;
  logic signed [NB_DATA-1:0] run_max, run_min;
  logic signed [NB_DATA-1:0] win_max, win_min;
  logic [NB_DATA:0]          win_pkpk;
  logic [NB_DATA-1:0]        win_mean;
  logic signed [NB_DATA-1:0] max_q, min_q;
  logic [NB_DATA:0]          pkpk_q;
  logic [NB_DATA-1:0]        mean_q;
  logic                      overrun_q;
  logic                      first, last, load, set_overrun;

  assign first = (count == '0);
  assign last  = bus.i_en && (&count);

  // Window statistics including the sample on the current edge, so the last
  // sample of a window lands in the result registers on its own edge.
  assign win_max  = (first || (bus.i_data > run_max)) ? bus.i_data : run_max;
  assign win_min  = (first || (bus.i_data < run_min)) ? bus.i_data : run_min;
  assign win_pkpk = {win_max[NB_DATA-1], win_max} - {win_min[NB_DATA-1], win_min};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count   <= '0;
      run_max <= '0;
      run_min <= '0;
    end else if (bus.i_en) begin
      count   <= count + 1'b1;
      run_max <= win_max;
      run_min <= win_min;
    end
  end

`ifdef LEVEL_DETECTOR_MEAN_ABS_EN
  logic [NB_SUM-1:0]  acc, acc_next;
  logic [NB_DATA-1:0] abs_x;

  // Most-negative input maps to 2^(NB_DATA-1), which still fits unsigned.
  assign abs_x    = bus.i_data[NB_DATA-1] ? -bus.i_data : bus.i_data;
  assign acc_next = (first ? '0 : acc) + NB_SUM'(abs_x);
  assign win_mean = acc_next[NB_SUM-1:LOG2_WIN];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc <= '0;
    end else if (bus.i_en) begin
      acc <= acc_next;
    end
  end
`else
  assign win_mean = '0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // A completing window is loaded if the slot is free or being drained on the
  // same edge; otherwise the held result wins and the drop is flagged.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    set_overrun = 1'b0;
    case (state)
      EMPTY: begin
        if (last) begin
          load       = 1'b1;
          next_state = PENDING;
        end
      end
      PENDING: begin
        if (last) begin
          if (bus.i_ready) begin
            load = 1'b1;
          end else begin
            set_overrun = 1'b1;
          end
        end else if (bus.i_ready) begin
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      max_q     <= '0;
      min_q     <= '0;
      pkpk_q    <= '0;
      mean_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        max_q  <= win_max;
        min_q  <= win_min;
        pkpk_q <= win_pkpk;
        mean_q <= win_mean;
      end
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.o_max      = max_q;
  assign bus.o_min      = min_q;
  assign bus.o_pkpk     = pkpk_q;
  assign bus.o_mean_abs = mean_q;
  assign bus.o_valid    = (state == PENDING);
  assign bus.o_overrun  = overrun_q;

endmodule
